// File: rtl/imem_dmem_arbiter_pkg.sv
// imem_dmem_arbiter_pkg: shared types for the IF/DM single-port SRAM arbiter
// Provides the arbiter FSM encoding, the response owner encoding and the requester bundle.
package imem_dmem_arbiter_pkg;
    typedef enum reg [1:0] {ARB_STARTUP, ARB_IDLE, ARB_BUSY} FSM_ARB_states;
    typedef enum bit [1:0] {OWN_NONE = 2'b00, OWN_IF = 2'b01, OWN_DM = 2'b10} ARB_Owner_Enum;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ARB_req;
endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// imem_dmem_arbiter_if: bus bundle between pipeline, arbiter and SRAM macro
// Fetch side:  if_req_i/if_addr_i/if_flush_i in, if_gnt_o/if_rvalid_o/if_rdata_o out.
// Data side:   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i in, dm_gnt_o/dm_rvalid_o/dm_rdata_o out.
// Memory side: mem_cs_o/mem_we_o/mem_addr_o/mem_wdata_o out, mem_rdata_i in.
// Hazard side: if_stall_o/dm_stall_o/ready_o out.
// slave is the arbiter's view, master is the surrounding system's view.
interface imem_dmem_arbiter_if #(parameter int AW = 32);
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_flush_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [31:0]   if_rdata_o;
    logic          dm_req_i;
    logic          dm_we_i;
    logic [AW-1:0] dm_addr_i;
    logic [31:0]   dm_wdata_i;
    logic          dm_gnt_o;
    logic          dm_rvalid_o;
    logic [31:0]   dm_rdata_o;
    logic          mem_cs_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;
    logic          if_stall_o;
    logic          dm_stall_o;
    logic          ready_o;
    modport slave (
        input  if_req_i, if_addr_i, if_flush_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
               mem_cs_o, mem_we_o, mem_addr_o, mem_wdata_o, if_stall_o, dm_stall_o, ready_o
    );
    modport master (
        output if_req_i, if_addr_i, if_flush_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
               mem_cs_o, mem_we_o, mem_addr_o, mem_wdata_o, if_stall_o, dm_stall_o, ready_o
    );
endinterface

// File: rtl/imem_dmem_arbiter_lat_counter.sv
// arb_lat_counter: loadable down-counter that stops at zero
// clk/rst: clock and asynchronous active-high reset (count cleared to 0).
// load/load_val: load a new count; load wins over the decrement.
// busy: count is non-zero. last: count equals 1.
module arb_lat_counter #(parameter int W = 3) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         busy,
    output logic         last
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    assign busy = cnt != '0;
    assign last = cnt == W'(1);
endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port SRAM between instruction fetch and load/store
// clk/rst: clock and asynchronous active-high reset.
// bus (slave): fetch and data request/grant/response, SRAM drive and read data,
//              stall qualifiers for the hazard unit and the startup-complete flag.
module imem_dmem_arbiter import imem_dmem_arbiter_pkg::*; #(
    parameter int AW       = 32,
    parameter int LAT      = 1,
    parameter int INIT_CYC = 4
) (
    input logic                clk,
    input logic                rst,
    imem_dmem_arbiter_if.slave bus
);
    localparam logic [1:0] ST_STARTUP = ARB_STARTUP;
    localparam logic [1:0] ST_IDLE    = ARB_IDLE;
    localparam logic [1:0] ST_BUSY    = ARB_BUSY;
    logic [1:0]    state;
    ARB_Owner_Enum owner;
    logic          kill;
    logic          st_load, st_busy, st_last, st_done;
    logic          lat_busy, lat_last;
    logic          can_gnt, dm_gnt, if_gnt, rd_gnt, if_rv, dm_rv;
    ARB_req        if_b, dm_b, win;

    // The startup counter is armed on the first STARTUP cycle with INIT_CYC-1, so the
    // last count lands on the INIT_CYC-th cycle; INIT_CYC==1 leaves on the first cycle.
    arb_lat_counter #(.W(4)) u_st (
        .clk(clk), .rst(rst), .load(st_load), .load_val(4'(INIT_CYC - 1)),
        .busy(st_busy), .last(st_last)
    );
    arb_lat_counter #(.W(3)) u_lat (
        .clk(clk), .rst(rst), .load(rd_gnt), .load_val(3'(LAT)),
        .busy(lat_busy), .last(lat_last)
    );

    assign st_load = state == ST_STARTUP && !st_busy;
    assign st_done = state == ST_STARTUP && (st_last || INIT_CYC == 1);

    // A grant may issue in the return cycle of the previous read, giving back-to-back
    // issue at LAT=1. A flushing fetch is never granted.
    assign can_gnt = state == ST_IDLE || (state == ST_BUSY && lat_last);
    assign dm_gnt  = can_gnt && bus.dm_req_i;
    assign if_gnt  = can_gnt && bus.if_req_i && !bus.dm_req_i && !bus.if_flush_i;
    assign rd_gnt  = if_gnt || (dm_gnt && !bus.dm_we_i);

    assign if_b = '{req: bus.if_req_i, we: 1'b0, addr: 32'(bus.if_addr_i), wdata: bus.dm_wdata_i};
    assign dm_b = '{req: bus.dm_req_i, we: bus.dm_we_i, addr: 32'(bus.dm_addr_i), wdata: bus.dm_wdata_i};
    assign win  = dm_gnt ? dm_b : if_gnt ? if_b : '0;

    assign bus.if_gnt_o    = if_gnt;
    assign bus.dm_gnt_o    = dm_gnt;
    assign bus.mem_cs_o    = win.req;
    assign bus.mem_we_o    = win.we;
    assign bus.mem_addr_o  = AW'(win.addr);
    assign bus.mem_wdata_o = win.wdata;

    // A killed fetch still occupies the SRAM slot; only its rvalid is dropped.
    assign if_rv = lat_last && owner == OWN_IF && !kill && !bus.if_flush_i;
    assign dm_rv = lat_last && owner == OWN_DM;
    assign bus.if_rvalid_o = if_rv;
    assign bus.dm_rvalid_o = dm_rv;
    assign bus.if_rdata_o  = if_rv ? bus.mem_rdata_i : '0;
    assign bus.dm_rdata_o  = dm_rv ? bus.mem_rdata_i : '0;
    assign bus.if_stall_o  = bus.if_req_i && !if_gnt;
    assign bus.dm_stall_o  = (bus.dm_req_i && !dm_gnt) || (owner == OWN_DM && lat_busy && !dm_rv);
    assign bus.ready_o     = state != ST_STARTUP;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= ST_STARTUP;
            owner <= OWN_NONE;
            kill  <= 1'b0;
        end else begin
            if (state == ST_STARTUP) state <= st_done ? ST_IDLE : ST_STARTUP;
            else if (rd_gnt) state <= ST_BUSY;
            else if (lat_last) state <= ST_IDLE;
            if (rd_gnt) owner <= if_gnt ? OWN_IF : OWN_DM;
            else if (lat_last) owner <= OWN_NONE;
            kill <= lat_last ? 1'b0 : kill | (bus.if_flush_i && owner == OWN_IF && lat_busy);
        end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: directed plus random check of the arbiter at LAT=1 and LAT=3
module tb_imem_dmem_arbiter;
    localparam int INIT = 4;

    typedef struct packed {
        logic        if_gnt;
        logic        dm_gnt;
        logic        if_rv;
        logic        dm_rv;
        logic [31:0] if_rd;
        logic [31:0] dm_rd;
        logic        cs;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        if_st;
        logic        dm_st;
        logic        rdy;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    obs_t        obs [2];
    logic [31:0] rp [2][8];
    logic [31:0] rd_next [2];
    logic [31:0] sram [2][256];
    logic [31:0] shadow [2][256];
    int          errors = 0;
    int          checks = 0;
    bit          booted = 1'b0;
    int          n [2];
    int          rem [2];
    bit          pv [2];
    bit          pif [2];
    bit          pkill [2];
    logic [31:0] pdata [2];
    bit          ret, free, e_ig, e_dg, e_irv, e_drv, e_cs;
    logic [31:0] e_addr;
    string       p;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        imem_dmem_arbiter_if #(.AW(32)) bus ();
        assign bus.if_req_i    = if_req;
        assign bus.if_addr_i   = if_addr;
        assign bus.if_flush_i  = if_flush;
        assign bus.dm_req_i    = dm_req;
        assign bus.dm_we_i     = dm_we;
        assign bus.dm_addr_i   = dm_addr;
        assign bus.dm_wdata_i  = dm_wdata;
        assign bus.mem_rdata_i = rp[g][g ? 2 : 0];
        assign obs[g] = '{bus.if_gnt_o, bus.dm_gnt_o, bus.if_rvalid_o, bus.dm_rvalid_o,
                          bus.if_rdata_o, bus.dm_rdata_o, bus.mem_cs_o, bus.mem_we_o,
                          bus.mem_addr_o, bus.mem_wdata_o, bus.if_stall_o, bus.dm_stall_o,
                          bus.ready_o};
        imem_dmem_arbiter #(.AW(32), .LAT(g ? 3 : 1), .INIT_CYC(INIT)) u_dut (
            .clk(clk), .rst(rst), .bus(bus)
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        return {22'h0, 8'($urandom), 2'b00};
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // SRAM emulation: a read issued in a cs cycle appears LAT cycles later.
    always @(posedge clk)
        for (int k = 0; k < 2; k++) begin
            rp[k][0] <= rd_next[k];
            for (int j = 1; j < 8; j++) rp[k][j] <= rp[k][j-1];
        end

    // Reference model: at most one read outstanding, tracked as a countdown to its return.
    always @(negedge clk) begin
        if (!booted) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 256; i++) begin
                    sram[k][i]   = 32'h1000_0000 + 32'(i * 4);
                    shadow[k][i] = 32'h1000_0000 + 32'(i * 4);
                end
            booted = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            p = k ? "L3" : "L1";
            if (obs[k].cs && obs[k].we) sram[k][obs[k].addr[9:2]] = obs[k].wdata;
            rd_next[k] = (obs[k].cs && !obs[k].we) ? sram[k][obs[k].addr[9:2]] : $urandom;
            if (rst) begin
                n[k]  = 0;
                pv[k] = 1'b0;
            end
            ret    = pv[k] && rem[k] == 1;
            free   = n[k] >= INIT && (!pv[k] || ret);
            e_dg   = free && dm_req;
            e_ig   = free && if_req && !dm_req && !if_flush;
            e_irv  = ret && pif[k] && !pkill[k] && !if_flush;
            e_drv  = ret && !pif[k];
            e_cs   = e_dg || e_ig;
            e_addr = e_dg ? dm_addr : e_ig ? if_addr : 32'h0;
            chk({p, "_if_gnt"}, 32'(obs[k].if_gnt), 32'(e_ig));
            chk({p, "_dm_gnt"}, 32'(obs[k].dm_gnt), 32'(e_dg));
            chk({p, "_if_rvalid"}, 32'(obs[k].if_rv), 32'(e_irv));
            chk({p, "_dm_rvalid"}, 32'(obs[k].dm_rv), 32'(e_drv));
            chk({p, "_if_rdata"}, obs[k].if_rd, e_irv ? pdata[k] : 32'h0);
            chk({p, "_dm_rdata"}, obs[k].dm_rd, e_drv ? pdata[k] : 32'h0);
            chk({p, "_mem_cs"}, 32'(obs[k].cs), 32'(e_cs));
            chk({p, "_mem_we"}, 32'(obs[k].we), 32'(e_dg && dm_we));
            chk({p, "_mem_addr"}, obs[k].addr, e_addr);
            chk({p, "_mem_wdata"}, obs[k].wdata, e_cs ? dm_wdata : 32'h0);
            chk({p, "_if_stall"}, 32'(obs[k].if_st), 32'(if_req && !e_ig));
            chk({p, "_dm_stall"}, 32'(obs[k].dm_st), 32'((dm_req && !e_dg) || (pv[k] && !pif[k] && !ret)));
            chk({p, "_ready"}, 32'(obs[k].rdy), 32'(n[k] >= INIT));
            if (!rst) begin
                if (n[k] < 64) n[k]++;
                if (ret) pv[k] = 1'b0;
                else if (pv[k]) begin
                    rem[k]--;
                    if (pif[k] && if_flush) pkill[k] = 1'b1;
                end
                if (e_dg && dm_we) shadow[k][dm_addr[9:2]] = dm_wdata;
                if (e_ig || (e_dg && !dm_we)) begin
                    pv[k]    = 1'b1;
                    pif[k]   = e_ig;
                    rem[k]   = k ? 3 : 1;
                    pdata[k] = shadow[k][e_addr[9:2]];
                    pkill[k] = 1'b0;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        {if_req, if_flush, dm_req, dm_we} = 4'b0;
        {if_addr, dm_addr, dm_wdata} = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", 32'(obs[0].cs), 32'd0);
        chk("rst_ready", 32'(obs[1].rdy), 32'd0);
        chk("rst_if_rvalid", 32'(obs[0].if_rv), 32'd0);
        nxt();
        rst = 1'b0;
        if_req = 1'b1;
        if_addr = 32'h40;
        for (int i = 0; i < INIT; i++) begin
            @(negedge clk);
            chk("startup_gnt", 32'(obs[0].if_gnt), 32'd0);
            chk("startup_ready", 32'(obs[1].rdy), 32'd0);
            nxt();
        end
        @(negedge clk);
        chk("ready_rise", 32'(obs[0].rdy), 32'd1);
        chk("if_gnt_40", 32'(obs[0].if_gnt), 32'd1);
        chk("addr_40", obs[0].addr, 32'h40);
        nxt();
        if_addr = 32'h44;
        @(negedge clk);
        chk("if_rdata_40", obs[0].if_rd, 32'h1000_0040);
        chk("if_gnt_44", 32'(obs[0].if_gnt), 32'd1);
        nxt();
        if_addr = 32'h48;
        @(negedge clk);
        chk("if_rdata_44", obs[0].if_rd, 32'h1000_0044);
        chk("addr_48", obs[0].addr, 32'h48);
        nxt();
        if_addr = 32'h4C;
        dm_req = 1'b1;
        dm_addr = 32'h80;
        @(negedge clk);
        chk("both_dm_gnt", 32'(obs[0].dm_gnt), 32'd1);
        chk("both_if_stall", 32'(obs[0].if_st), 32'd1);
        nxt();
        dm_req = 1'b0;
        @(negedge clk);
        chk("dm_rvalid_80", 32'(obs[0].dm_rv), 32'd1);
        chk("dm_rdata_80", obs[0].dm_rd, 32'h1000_0080);
        chk("if_gnt_after_dm", 32'(obs[0].if_gnt), 32'd1);
        nxt();
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 32'h100;
        dm_wdata = 32'hDEAD_BEEF;
        if_addr = 32'h50;
        @(negedge clk);
        chk("store_we", 32'(obs[0].we), 32'd1);
        chk("store_wdata", obs[0].wdata, 32'hDEAD_BEEF);
        chk("store_addr", obs[0].addr, 32'h100);
        nxt();
        dm_req = 1'b0;
        dm_we = 1'b0;
        @(negedge clk);
        chk("post_store_if_gnt", 32'(obs[0].if_gnt), 32'd1);
        chk("store_no_rvalid", 32'(obs[0].dm_rv), 32'd0);
        nxt();
        if_addr = 32'h100;
        nxt();
        if_req = 1'b0;
        @(negedge clk);
        chk("readback_store", obs[0].if_rd, 32'hDEAD_BEEF);
        repeat (8) nxt();
        if_req = 1'b1;
        if_addr = 32'h60;
        @(negedge clk);
        chk("l3_if_gnt_60", 32'(obs[1].if_gnt), 32'd1);
        nxt();
        if_req = 1'b0;
        if_flush = 1'b1;
        nxt();
        if_flush = 1'b0;
        nxt();
        if_req = 1'b1;
        if_addr = 32'h64;
        @(negedge clk);
        chk("l3_killed_rvalid", 32'(obs[1].if_rv), 32'd0);
        chk("l3_if_gnt_64", 32'(obs[1].if_gnt), 32'd1);
        nxt();
        if_req = 1'b0;
        repeat (2) nxt();
        @(negedge clk);
        chk("l3_rvalid_64", 32'(obs[1].if_rv), 32'd1);
        chk("l3_rdata_64", obs[1].if_rd, 32'h1000_0064);
        nxt();
        dm_req = 1'b1;
        dm_addr = 32'h80;
        @(negedge clk);
        chk("l3_dm_gnt", 32'(obs[1].dm_gnt), 32'd1);
        nxt();
        rst = 1'b1;
        @(negedge clk);
        chk("l3_rst_cs", 32'(obs[1].cs), 32'd0);
        chk("l3_rst_ready", 32'(obs[1].rdy), 32'd0);
        nxt();
        dm_req = 1'b0;
        nxt();
        @(negedge clk);
        chk("l3_rst_no_rvalid", 32'(obs[1].dm_rv), 32'd0);
        nxt();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            nxt();
            rst      = !rst && $urandom_range(0, 299) == 0;
            if_req   = $urandom_range(0, 3) != 0;
            if_addr  = rnd_addr();
            if_flush = $urandom_range(0, 5) == 0;
            dm_req   = $urandom_range(0, 2) == 0;
            dm_we    = $urandom_range(0, 1) == 0;
            dm_addr  = rnd_addr();
            dm_wdata = $urandom;
        end
        nxt();
        {rst, if_req, if_flush, dm_req, dm_we} = 5'b0;
        repeat (2) nxt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
Shares one single-port synchronous SRAM between two requesters: the instruction fetch stage (IF) and the load/store stage (DM). The block sequences a power-up wait, grants one access per cycle with fixed priority to DM, and tracks the fixed-latency read return. It drives stall qualifiers to the hazard unit and sits between the pipeline front/back ends and the memory macro.

Parameters:
AW, 32, address width
LAT, 1, SRAM read latency in cycles (1..7)
INIT_CYC, 4, cycles held in startup after reset before the first grant (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
if_req_i  in  1  fetch read request
if_addr_i  in  AW  fetch address
if_flush_i  in  1  branch/jump redirect; kills the in-flight fetch response
if_gnt_o  out  1  fetch accepted this cycle
if_rvalid_o  out  1  fetch data valid
if_rdata_o  out  32  fetch data
dm_req_i  in  1  data request
dm_we_i  in  1  1 = store, 0 = load
dm_addr_i  in  AW  data address
dm_wdata_i  in  32  store data
dm_gnt_o  out  1  data access accepted this cycle
dm_rvalid_o  out  1  load data valid
dm_rdata_o  out  32  load data
mem_cs_o  out  1  SRAM chip select
mem_we_o  out  1  SRAM write enable
mem_addr_o  out  AW  SRAM address
mem_wdata_o  out  32  SRAM write data
mem_rdata_i  in  32  SRAM read data, valid LAT cycles after the cs cycle
if_stall_o  out  1  fetch requested but not granted (freezes PC and IF/ID)
dm_stall_o  out  1  data requested but not granted, or load issued and not yet returned
ready_o  out  1  startup complete

Behaviour:
- States: STARTUP, IDLE, BUSY.
- Reset value of every output is 0. The state is STARTUP, the counters are 0, and the owner is NONE. Reset mid-transaction aborts it: no rvalid follows, and mem_cs_o drops immediately.
- STARTUP: count INIT_CYC cycles. No grants; ready_o=0. On the last count go to IDLE; ready_o=1 from the next cycle and stays 1 until reset.
- Grants are combinational in the same cycle.
  - Grant is allowed when state=IDLE, or state=BUSY with lat_cnt==1 (the return cycle). This gives back-to-back issue when LAT=1.
  - DM has priority over IF.
  - IF is granted only if if_req_i=1, no DM request exists, and if_flush_i=0.
  - At most one gnt per cycle.
- Memory drive on a grant:
  - mem_cs_o=1.
  - mem_addr_o comes from the winner.
  - mem_we_o=dm_we_i on a DM grant, else 0.
  - mem_wdata_o=dm_wdata_i.
  - With no grant: cs=0, we=0, addr/wdata=0.
- Read grant (IF or DM load): lat_cnt<=LAT, owner<=IF/DM, state<=BUSY. lat_cnt decrements each cycle.
- When lat_cnt==1 the owner's rvalid=1 and rdata=mem_rdata_i. Exactly one cycle, LAT cycles after the grant.
- Without a new read grant in that cycle, the state goes to IDLE and owner goes to NONE.
- Store grant: single cycle, no response. The counter is not loaded. If the store is granted in a return cycle, the state goes to IDLE.
- rdata outputs are 0 whenever the matching rvalid is 0.
- Flush:
  - if_flush_i=1 while owner=IF and lat_cnt>0 sets a kill flag.
  - The returning response is then dropped: if_rvalid_o=0. The memory cycle still completes and the arbiter is still busy.
  - A flush in the return cycle itself also suppresses that rvalid.
  - The kill flag clears on return.
- if_stall_o = if_req_i & ~if_gnt_o.
- dm_stall_o = (dm_req_i & ~dm_gnt_o) | (owner==DM & lat_cnt>0 & ~dm_rvalid_o).
- Simultaneous IF+DM requests: DM wins and IF stalls. IF starvation is bounded by the pipeline: DM requests stop while the pipe is stalled behind IF.

Decomposition:
- Package additions:
  - typedef enum reg [1:0] FSM_ARB_states {ARB_STARTUP, ARB_IDLE, ARB_BUSY}.
  - typedef enum bit [1:0] ARB_Owner_Enum {OWN_NONE=2'b00, OWN_IF=2'b01, OWN_DM=2'b10}.
  - packed struct ARB_req {req, we, addr[31:0], wdata[31:0]} for each requester bundle.
- One sub-module, arb_lat_counter: loadable down-counter exposing a busy flag and a last flag (lat_cnt==1). Reused for the startup count.

Test Plan:
1. Reset, idle requests, INIT_CYC=4 -> no gnt for 4 cycles; ready_o rises in cycle 5; all outputs 0 during reset.
2. IF read 0x40 alone, LAT=1 -> if_gnt_o=1, mem_cs_o=1, mem_addr_o=0x40 in cycle t; if_rvalid_o=1 with the SRAM word in t+1; continuous fetch 0x44, 0x48 granted every cycle.
3. IF and DM load both requested in one cycle -> dm_gnt_o=1, if_stall_o=1; IF granted in the following cycle (LAT=1), so dm_rvalid_o and if_gnt_o coincide.
4. DM store 0x100 with wdata 0xDEADBEEF -> mem_we_o=1, mem_wdata_o=0xDEADBEEF for one cycle; no rvalid; IF granted the next cycle.
5. LAT=3: IF read granted at t, if_flush_i pulsed at t+1 -> if_rvalid_o stays 0 at t+3; new IF granted at t+3 and returns at t+6.
6. rst asserted at t+1 of an LAT=3 load -> mem_cs_o=0 immediately, no dm_rvalid_o, state=STARTUP, ready_o=0.
